router_node_port: RTL

Router-side endpoint of the byte-serial node↔router link. It has two independent halves:

- **Receive half:** deserializes the 4-byte bursts a node sends on `put_outbound`/`payload_outbound` into a held `pkt_t`.
- **Transmit half:** queues `pkt_t` packets from the router core and serializes them to the node on `put_inbound`/`payload_inbound`.

One instance sits between each node and the router core. It replaces the separate router input and output buffers.

---
 rtl/router_node_port.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/router_node_port.sv
// Router-side endpoint of the byte-serial node<->router link: a receive half that
// assembles 4-byte bursts into a held packet, and a transmit half that queues and serializes packets.
module router_node_port #(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        put_outbound,
  input  logic [7:0]  payload_outbound,
  output logic        free_outbound,
  output logic        put_inbound,
  output logic [7:0]  payload_inbound,
  input  logic        free_inbound,
  output logic [31:0] in_pkt,
  output logic        in_pkt_avail,
  input  logic        in_pkt_taken,
  input  logic [31:0] out_pkt,
  input  logic        out_pkt_we,
  output logic        out_full,
  output logic        out_empty
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  typedef logic [31:0] pkt_t;
  typedef enum logic [1:0] {RX_FREE, RX_COLLECT, RX_HOLD} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  logic [1:0] rx_cnt_q, rx_cnt_d;
  pkt_t       in_pkt_q, in_pkt_d;
  logic       free_out_q;

  tx_state_e tx_state_q, tx_state_d;
  logic [1:0] sel_q, sel_d;
  pkt_t       send_q, send_d;
  logic       put_in_q;

  pkt_t          mem_q [OUT_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Receive half
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    in_pkt_d   = in_pkt_q;
    case (rx_state_q)
      RX_FREE: begin
        if (put_outbound) begin
          in_pkt_d[7:0] = payload_outbound;
          rx_cnt_d      = 2'd1;
          rx_state_d    = RX_COLLECT;
        end
      end
      RX_COLLECT: begin
        if (put_outbound) begin
          in_pkt_d[8*rx_cnt_q +: 8] = payload_outbound;
          rx_cnt_d                  = rx_cnt_q + 2'd1;
          if (rx_cnt_q == 2'd3) rx_state_d = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (in_pkt_taken) rx_state_d = RX_FREE;
      end
      default: rx_state_d = RX_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rx_state_q <= RX_FREE;
      rx_cnt_q   <= '0;
      in_pkt_q   <= '0;
      free_out_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      in_pkt_q   <= in_pkt_d;
      free_out_q <= (rx_state_d == RX_FREE);
    end
  end

  assign free_outbound = free_out_q;
  assign in_pkt        = in_pkt_q;
  assign in_pkt_avail  = (rx_state_q == RX_HOLD);

  // Outbound queue; pointers wrap naturally because OUT_DEPTH is a power of two
  assign out_full  = (count_q == CW'(OUT_DEPTH));
  assign out_empty = (count_q == '0);
  assign push      = out_pkt_we && !out_full;
  assign pop       = (tx_state_q == TX_IDLE) && !out_empty && free_inbound;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= out_pkt;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Transmit half
  always_comb begin
    tx_state_d = tx_state_q;
    sel_d      = sel_q;
    send_d     = send_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (pop) begin
          send_d     = mem_q[rd_ptr_q];
          sel_d      = 2'd0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        sel_d = sel_q + 2'd1;
        if (sel_q == 2'd3) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_state_q <= TX_IDLE;
      sel_q      <= '0;
      send_q     <= '0;
      put_in_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      sel_q      <= sel_d;
      send_q     <= send_d;
      put_in_q   <= (tx_state_d == TX_SEND);
    end
  end

  // Byte lane is forced to zero outside a burst so the link idles quiet
  assign put_inbound     = put_in_q;
  assign payload_inbound = (tx_state_q == TX_SEND) ? send_q[8*sel_q +: 8] : 8'h00;

endmodule
